// File: rtl/dump_ctrl.sv
// dump_ctrl: sequences readout of a channel capture RAM to the UART TX.
// On strt_rd it latches the channel, starts at the oldest sample (waddr) and
// walks all ENTRIES locations of the circular buffer, sending each byte via a
// send_byte / resp_sent handshake. rd_done pulses once when the dump ends.
//
// Optional feature (compile-time macro DUMP_CHKSUM_EN): appends one extra byte,
// the modulo-256 sum of all data bytes, after the last data byte.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   strt_rd                 one-cycle dump request (ignored while busy)
//   channel[2:0]            channel to dump (1..5), sampled at strt_rd
//   waddr                   capture write pointer = oldest sample
//   rdataCH1..rdataCH5      registered RAM read data (1-cycle latency)
//   resp_sent               UART TX finished the current byte
//   raddr                   shared RAM read address
//   dump_byte, send_byte    byte to transmit and its one-cycle start pulse
//   busy                    dump in progress
//   rd_done                 one-cycle pulse at dump completion
module dump_ctrl #(
  parameter int ENTRIES      = 384,
  parameter int LOG2_ENTRIES = 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    strt_rd,
  input  logic [2:0]              channel,
  input  logic [LOG2_ENTRIES-1:0] waddr,
  input  logic [7:0]              rdataCH1,
  input  logic [7:0]              rdataCH2,
  input  logic [7:0]              rdataCH3,
  input  logic [7:0]              rdataCH4,
  input  logic [7:0]              rdataCH5,
  input  logic                    resp_sent,
  output logic [LOG2_ENTRIES-1:0] raddr,
  output logic [7:0]              dump_byte,
  output logic                    send_byte,
  output logic                    busy,
  output logic                    rd_done
);

  localparam logic [LOG2_ENTRIES-1:0] LAST = LOG2_ENTRIES'(ENTRIES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_LATCH,
    S_WAIT,
    S_DONE
`ifdef DUMP_CHKSUM_EN
    , S_CHK
`endif
  } state_t;

  state_t                  state, state_n;
  logic [2:0]              ch_q, ch_n;
  logic [LOG2_ENTRIES-1:0] cnt, cnt_n;
  logic [LOG2_ENTRIES-1:0] raddr_n;
  logic [7:0]              dump_n;
  logic                    send_n, busy_n, done_n;
  logic [7:0]              rd_sel;
`ifdef DUMP_CHKSUM_EN
  logic [7:0]              sum, sum_n;
  // Set once the checksum byte is in flight, so WAIT knows it is the final byte.
  logic                    chk_ph, chk_n;
`endif

  always_comb begin
    unique case (ch_q)
      3'd1:    rd_sel = rdataCH1;
      3'd2:    rd_sel = rdataCH2;
      3'd3:    rd_sel = rdataCH3;
      3'd4:    rd_sel = rdataCH4;
      3'd5:    rd_sel = rdataCH5;
      default: rd_sel = '0;
    endcase
  end

  always_comb begin
    state_n = state;
    ch_n    = ch_q;
    cnt_n   = cnt;
    raddr_n = raddr;
    dump_n  = dump_byte;
    send_n  = 1'b0;
    busy_n  = busy;
    done_n  = 1'b0;
`ifdef DUMP_CHKSUM_EN
    sum_n   = sum;
    chk_n   = chk_ph;
`endif
    case (state)
      S_IDLE: begin
        if (strt_rd) begin
          ch_n    = channel;
          raddr_n = (waddr <= LAST) ? waddr : '0;
          cnt_n   = '0;
          busy_n  = 1'b1;
          state_n = S_RD;
`ifdef DUMP_CHKSUM_EN
          sum_n   = '0;
          chk_n   = 1'b0;
`endif
        end
      end
      S_RD: state_n = S_LATCH;
      S_LATCH: begin
        dump_n  = rd_sel;
        send_n  = 1'b1;
        state_n = S_WAIT;
`ifdef DUMP_CHKSUM_EN
        sum_n   = sum + rd_sel;
`endif
      end
      S_WAIT: begin
        if (resp_sent) begin
`ifdef DUMP_CHKSUM_EN
          if (chk_ph) state_n = S_DONE;
          else
`endif
          if (cnt == LAST) begin
`ifdef DUMP_CHKSUM_EN
            state_n = S_CHK;
`else
            state_n = S_DONE;
`endif
          end else begin
            cnt_n   = cnt + 1'b1;
            raddr_n = (raddr == LAST) ? '0 : raddr + 1'b1;
            state_n = S_RD;
          end
        end
      end
`ifdef DUMP_CHKSUM_EN
      S_CHK: begin
        dump_n  = sum;
        send_n  = 1'b1;
        chk_n   = 1'b1;
        state_n = S_WAIT;
      end
`endif
      S_DONE: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ch_q      <= '0;
      cnt       <= '0;
      raddr     <= '0;
      dump_byte <= '0;
      send_byte <= 1'b0;
      busy      <= 1'b0;
      rd_done   <= 1'b0;
`ifdef DUMP_CHKSUM_EN
      sum       <= '0;
      chk_ph    <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      ch_q      <= ch_n;
      cnt       <= cnt_n;
      raddr     <= raddr_n;
      dump_byte <= dump_n;
      send_byte <= send_n;
      busy      <= busy_n;
      rd_done   <= done_n;
`ifdef DUMP_CHKSUM_EN
      sum       <= sum_n;
      chk_ph    <= chk_n;
`endif
    end
  end

endmodule

// File: tb/tb_dump_ctrl.sv
// Self-checking bench for dump_ctrl: RAM and UART responder models, a
// byte-stream model of each dump and a per-cycle compare process.
module tb_dump_ctrl;
  localparam int ENTRIES = 384;
  localparam int LOG2    = 9;
`ifdef DUMP_CHKSUM_EN
  localparam int NBYTES  = ENTRIES + 1;
`else
  localparam int NBYTES  = ENTRIES;
`endif

  logic            clk, rst_n, strt_rd, resp_sent;
  logic [2:0]      channel;
  logic [LOG2-1:0] waddr, raddr;
  logic [7:0]      rdataCH1, rdataCH2, rdataCH3, rdataCH4, rdataCH5;
  logic [7:0]      dump_byte;
  logic            send_byte, busy, rd_done;

  dump_ctrl #(.ENTRIES(ENTRIES), .LOG2_ENTRIES(LOG2)) dut (
    .clk(clk), .rst_n(rst_n), .strt_rd(strt_rd), .channel(channel),
    .waddr(waddr), .rdataCH1(rdataCH1), .rdataCH2(rdataCH2),
    .rdataCH3(rdataCH3), .rdataCH4(rdataCH4), .rdataCH5(rdataCH5),
    .resp_sent(resp_sent), .raddr(raddr), .dump_byte(dump_byte),
    .send_byte(send_byte), .busy(busy), .rd_done(rd_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Channel RAMs with registered read
  logic [7:0] mem [1:5][ENTRIES];
  always @(posedge clk) begin
    if (int'(raddr) < ENTRIES) begin
      rdataCH1 <= mem[1][raddr];
      rdataCH2 <= mem[2][raddr];
      rdataCH3 <= mem[3][raddr];
      rdataCH4 <= mem[4][raddr];
      rdataCH5 <= mem[5][raddr];
    end
  end

  // UART responder: resp_sent resp_delay cycles after send_byte, or in the
  // same cycle when zero_lat is set.
  int   resp_delay;
  bit   zero_lat;
  logic resp_r;
  int   rc;
  assign resp_sent = zero_lat ? send_byte : resp_r;
  initial begin
    resp_r = 1'b0;
    rc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        resp_r = 1'b0;
        rc = 0;
      end else begin
        resp_r = 1'b0;
        if (send_byte && !zero_lat) rc = resp_delay;
        else if (rc > 0) begin
          rc--;
          if (rc == 0) resp_r = 1'b1;
        end
      end
    end
  end

  int tests = 0;
  int fails = 0;
  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected byte stream and addresses for the dump in progress
  int         exp_q[$];
  int         exp_a[$];
  int         dump_sent = 0;
  int         done_cnt  = 0;
  logic [7:0] last_sent;
  logic       prev_send, prev_done;
  int         log_b [NBYTES];
  int         log_a [NBYTES];

  always @(negedge clk) begin
    if (!rst_n) begin
      last_sent = '0;
      prev_send = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (send_byte) begin
        if (exp_q.size() == 0) check("extra_send", 1, 0);
        else begin
          check("dump_byte", int'(dump_byte), exp_q.pop_front());
          check("raddr_at_send", int'(raddr), exp_a.pop_front());
        end
        check("busy_during_send", int'(busy), 1);
        check("send_one_cycle", int'(prev_send), 0);
        if (dump_sent < NBYTES) begin
          log_b[dump_sent] = int'(dump_byte);
          log_a[dump_sent] = int'(raddr);
        end
        dump_sent++;
        last_sent = dump_byte;
      end else begin
        check("dump_byte_held", int'(dump_byte), int'(last_sent));
      end
      if (rd_done) begin
        check("rd_done_all_sent", exp_q.size(), 0);
        check("busy_low_at_done", int'(busy), 0);
        check("done_one_cycle", int'(prev_done), 0);
        done_cnt++;
      end
      prev_send = send_byte;
      prev_done = rd_done;
    end
  end

  task automatic start_dump(input int ch, input int wa);
    int st;
    int s;
    int a;
    int b;
    st = (wa < ENTRIES) ? wa : 0;
    s  = 0;
    exp_q.delete();
    exp_a.delete();
    for (int i = 0; i < ENTRIES; i++) begin
      a = (st + i) % ENTRIES;
      b = 0;
      if (ch >= 1 && ch <= 5) b = int'(mem[ch][a]);
      exp_q.push_back(b);
      exp_a.push_back(a);
      s = (s + b) % 256;
    end
`ifdef DUMP_CHKSUM_EN
    exp_q.push_back(s);
    exp_a.push_back((st + ENTRIES - 1) % ENTRIES);
`endif
    dump_sent = 0;
    @(negedge clk);
    channel = 3'(ch);
    waddr   = LOG2'(wa);
    strt_rd = 1'b1;
    @(negedge clk);
    strt_rd = 1'b0;
    check("busy_after_strt", int'(busy), 1);
    check("no_send_n1", int'(send_byte), 0);
    @(negedge clk);
    check("no_send_n2", int'(send_byte), 0);
    @(negedge clk);
    check("send_at_n3", int'(send_byte), 1);
  endtask

  task automatic wait_done(input string name);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < NBYTES * 16 + 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_seen"}, done_cnt - d0, 1);
    check({name, "_bytes"}, dump_sent, NBYTES);
    repeat (5) @(negedge clk);
    check({name, "_single_done"}, done_cnt - d0, 1);
    check({name, "_idle_busy"}, int'(busy), 0);
  endtask

  task automatic wait_sent(input int cnt, input string name);
    int n;
    n = 0;
    while (dump_sent < cnt && n < cnt * 16 + 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_reached"}, int'(dump_sent >= cnt), 1);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_busy"}, int'(busy), 0);
    check({name, "_raddr"}, int'(raddr), 0);
    check({name, "_dump_byte"}, int'(dump_byte), 0);
    check({name, "_send"}, int'(send_byte), 0);
    check({name, "_rd_done"}, int'(rd_done), 0);
  endtask

  initial begin
    int d0;
    rst_n = 1'b0; strt_rd = 1'b0; channel = '0; waddr = '0;
    resp_delay = 10; zero_lat = 1'b0;
    for (int a = 0; a < ENTRIES; a++) begin
      mem[1][a] = 8'(a);
      mem[2][a] = ~8'(a);
      mem[3][a] = 8'(a * 3 + 7);
      mem[4][a] = 8'(a ^ 8'h5A);
      mem[5][a] = 8'(a >> 1);
    end
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset");

    // Channel 1 from address 0
    start_dump(1, 0);
    wait_done("ch1_w0");
    check("ch1_byte0", log_b[0], 8'h00);
    check("ch1_byte127", log_b[127], 8'h7F);
    check("ch1_byte128", log_b[128], 8'h80);
    check("ch1_byte383", log_b[383], 8'h7F);
    check("ch1_addr0", log_a[0], 0);

    // Channel 3 starting at the last address, wraps to 0
    start_dump(3, 383);
    wait_done("ch3_w383");
    check("ch3_addr0", log_a[0], 383);
    check("ch3_addr1", log_a[1], 0);
    check("ch3_addr383", log_a[383], 382);
    check("ch3_byte1", log_b[1], 7);

    // Invalid channel, resp_sent in the same cycle as send_byte
    zero_lat = 1'b1;
    start_dump(6, 10);
    wait_done("ch6");
    check("ch6_byte200", log_b[200], 0);

    // waddr beyond ENTRIES starts at 0
    start_dump(2, 400);
    wait_done("ch2_w400");
    check("ch2_addr0", log_a[0], 0);
    check("ch2_byte0", log_b[0], 8'hFF);
    zero_lat = 1'b0;

    // Second strt_rd mid-dump is ignored
    start_dump(1, 100);
    wait_sent(50, "mid");
    @(negedge clk);
    channel = 3'd2;
    strt_rd = 1'b1;
    @(negedge clk);
    strt_rd = 1'b0;
    wait_done("mid_strt");
    check("mid_byte0", log_b[0], 100);
    check("mid_byte60", log_b[60], 160);

    // Reset mid-dump, then restart
    start_dump(1, 200);
    wait_sent(100, "rst");
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    exp_a.delete();
    @(negedge clk);
    check_idle_outputs("mid_reset");
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (40) @(negedge clk);
    check("no_done_after_reset", done_cnt - d0, 0);
    check("idle_after_reset", int'(busy), 0);
    start_dump(1, 5);
    wait_done("restart");
    check("restart_byte0", log_b[0], 5);
    check("restart_addr383", log_a[383], 4);

`ifdef DUMP_CHKSUM_EN
    for (int a = 0; a < ENTRIES; a++) mem[1][a] = 8'h01;
    start_dump(1, 0);
    wait_done("chksum");
    check("chksum_byte", log_b[384], 8'h80);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dump_ctrl.md
Name: dump_ctrl

Overview:
- Sequences the readout of the capture RAM after a capture completes.
- On a dump request it walks all ENTRIES locations of the circular capture buffer for one channel, oldest sample first.
- Each selected byte goes to the UART transmitter through a send/sent handshake.
- It sits between the command configuration block, which supplies strt_rd and the channel and consumes rd_done, and the channel RAMs plus the UART TX.

Parameters:
- ENTRIES, 384, depth of each channel capture RAM, in bytes.
- LOG2_ENTRIES, 9, width of the RAM address; must satisfy 2^LOG2_ENTRIES >= ENTRIES.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- strt_rd  input  1  one-cycle dump request from the command block.
- channel  input  3  channel to dump: 1..5 select CH1..CH5.
- waddr  input  LOG2_ENTRIES  capture write pointer, which is the oldest sample once capture is done.
- rdataCH1..rdataCH5  input  8 each  registered RAM read data, valid 1 cycle after raddr.
- resp_sent  input  1  UART TX finished the current byte.
- raddr  output  LOG2_ENTRIES  read address shared by all channel RAMs.
- dump_byte  output  8  byte presented to UART TX.
- send_byte  output  1  one-cycle pulse that starts a UART transmit of dump_byte.
- busy  output  1  high while a dump is in progress.
- rd_done  output  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset values: state IDLE; raddr=0, dump_byte=0x00, send_byte=0, busy=0, rd_done=0; byte counter=0; latched channel=0.
- All outputs are registered.
- States: IDLE, RD, LATCH, WAIT, DONE (plus CHK when the optional feature is enabled).
- IDLE, on strt_rd:
  - latch channel;
  - raddr <= (waddr < ENTRIES) ? waddr : 0;
  - counter <= 0; busy <= 1;
  - next state RD.
- strt_rd while busy is ignored. channel is sampled only at strt_rd.
- RD: raddr is stable and the RAM samples it; go to LATCH.
- LATCH:
  - dump_byte <= rdata of the latched channel;
  - channel 0, 6 or 7 gives 0x00, and the byte is still sent;
  - send_byte <= 1 for exactly one cycle; go to WAIT.
- Latency: strt_rd sampled at cycle N gives send_byte high in cycle N+3, with dump_byte valid in that same cycle.
- WAIT:
  - dump_byte is held;
  - resp_sent is honoured in any WAIT cycle, including the cycle where send_byte is high;
  - on resp_sent with counter == ENTRIES-1: go to DONE;
  - otherwise: counter++, raddr <= (raddr == ENTRIES-1) ? 0 : raddr+1, and go to RD.
- Wrap-around: raddr never reaches ENTRIES. Exactly ENTRIES bytes are sent per dump, whatever the start address.
- DONE: rd_done <= 1 and busy <= 0 in the same cycle, both for 1 cycle; return to IDLE. strt_rd in that cycle is ignored.
- resp_sent outside WAIT is ignored.
- Reset mid-dump: return immediately to the reset values. No rd_done is produced.
- Per-byte cycle cost: 3 cycles plus the UART time.

Optional Feature:
- Macro: DUMP_CHKSUM_EN.
- When defined:
  - an 8-bit running sum, modulo 256, accumulates every dump_byte sent and is cleared on strt_rd;
  - after the last data byte's resp_sent, the block enters CHK: dump_byte <= sum, send_byte pulses, and it waits for resp_sent;
  - then DONE.
  - The total is ENTRIES+1 bytes.
- When undefined: no CHK state and no sum register; DONE follows the last data byte directly.

Test Plan:
- waddr=0, channel=1, CH1 RAM holds addr[7:0]; resp_sent 10 cycles after each send_byte -> 384 bytes sent in order 0x00..0x7F,0x80..0xFF,0x00..0x7F; the first send_byte is 3 cycles after strt_rd; rd_done pulses once.
- waddr=383, channel=3 -> raddr sequence 383,0,1,...,382; exactly 384 send_byte pulses.
- channel=6 -> 384 bytes, all 0x00; rd_done pulses.
- A second strt_rd mid-dump with channel=2 -> ignored; channel 1 data continues and the byte count is unchanged.
- rst_n low after byte 100 -> busy=0, raddr=0, no rd_done; a subsequent strt_rd restarts cleanly from waddr.
- With DUMP_CHKSUM_EN and CH1 all 0x01 -> 385th byte = 384 mod 256 = 0x80; rd_done only after its resp_sent.
